aes_key_expand_seq: RTL



---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers: schedule word type, key-expansion FSM states,
// round-constant table and the RotWord helper.
package aes_pkg;

    typedef logic [0:31] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    // Rcon indices are 1-based (i/Nk); anything outside 1..10 yields zero.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[idx - 4'd1];
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Also used by the cipher datapath.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n occupies bits [8n : 8n+7], MSB first.
    assign out_byte = SBOX[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one word w[i] per clock into a 4*(Nr+1)-word
// store, with a random-access 128-bit round-key read port.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:Nk*32-1]  key,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              sched_valid,
    input  logic [3:0]        rk_idx,
    output logic [0:127]      rk_out
);

    localparam int NW = 4 * (Nr + 1);
    localparam int CW = $clog2(NW);

    state_t         state_r;
    state_t         next_state_s;
    logic [CW-1:0]  cnt_r;
    logic [2:0]     mod_r;
    logic [3:0]     rcon_idx_r;
    logic           key_ready_r;
    logic           sched_valid_r;
    word_t          w_r [0:NW-1];

    logic           accept_s;
    logic           expand_s;
    logic           last_s;
    logic [CW-1:0]  prev_idx_s;
    logic [CW-1:0]  old_idx_s;
    word_t          prev_word_s;
    word_t          old_word_s;
    word_t          sub_in_s;
    word_t          sub_out_s;
    word_t          temp_s;
    word_t          new_word_s;
    logic [CW-1:0]  base_s;

    // Next-state and control strobes for the expansion FSM.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        expand_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (key_valid && key_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = EXPAND;
                end else begin
                    next_state_s = state_r;
                end
            end
            EXPAND: begin
                expand_s = 1'b1;
                if (cnt_r == CW'(NW - 1)) begin
                    last_s       = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = EXPAND;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register, word/mod/Rcon counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
            mod_r         <= 3'd0;
            rcon_idx_r    <= 4'd1;
            key_ready_r   <= 1'b1;
            sched_valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cnt_r         <= CW'(Nk);
                mod_r         <= 3'd0;
                rcon_idx_r    <= 4'd1;
                key_ready_r   <= 1'b0;
                sched_valid_r <= 1'b0;
            end else if (expand_s) begin
                cnt_r <= cnt_r + CW'(1);
                mod_r <= (mod_r == 3'(Nk - 1)) ? 3'd0 : mod_r + 3'd1;
                if (mod_r == 3'd0) begin
                    rcon_idx_r <= rcon_idx_r + 4'd1;
                end
                if (last_s) begin
                    key_ready_r   <= 1'b1;
                    sched_valid_r <= 1'b1;
                end
            end
        end
    end

    // Schedule storage; deliberately not cleared by reset, the read port masks it.
    always_ff @(posedge clk) begin
        if (rst_n && accept_s) begin
            for (int k = 0; k < Nk; k++) begin
                w_r[k] <= key[k*32 +: 32];
            end
        end else if (rst_n && expand_s) begin
            w_r[cnt_r] <= new_word_s;
        end
    end

    assign prev_idx_s  = cnt_r - CW'(1);
    assign old_idx_s   = cnt_r - CW'(Nk);
    assign prev_word_s = w_r[prev_idx_s];
    assign old_word_s  = w_r[old_idx_s];
    assign sub_in_s    = (mod_r == 3'd0) ? rot_word(prev_word_s) : prev_word_s;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (sub_in_s[b*8 +: 8]),
            .out_byte (sub_out_s[b*8 +: 8])
        );
    end

    // Per-word temp selection: RotWord/SubWord/Rcon, AES-256 mid-key SubWord, or passthrough.
    always_comb begin
        temp_s = prev_word_s;
        if (mod_r == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_byte(rcon_idx_r), 24'h000000};
        end else if (Nk == 8 && mod_r == 3'd4) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_word_s;
        end
    end

    assign new_word_s = old_word_s ^ temp_s;

    assign base_s = CW'({rk_idx, 2'b00});

    // Round-key read port, zero unless the schedule is complete and the index is legal.
    always_comb begin
        rk_out = 128'h0;
        if (sched_valid_r && rk_idx <= 4'(Nr)) begin
            rk_out = {w_r[base_s], w_r[base_s + CW'(1)],
                      w_r[base_s + CW'(2)], w_r[base_s + CW'(3)]};
        end else begin
            rk_out = 128'h0;
        end
    end

    assign key_ready   = key_ready_r;
    assign sched_valid = sched_valid_r;

endmodule
